// File: rtl/aes_enc_round_ctrl.sv
// AES-128 encryption round sequencer: steps the round/round-key index 0..NR for
// one block per start handshake and holds the finished result until taken.
module aes_enc_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          in_ready,
  output logic [RW-1:0] round,
  output logic          sel_init,
  output logic          sel_final,
  output logic          state_we,
  output logic          busy,
  output logic          out_valid,
  output logic [CW-1:0] block_count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [RW-1:0] ROUND_LAST = RW'(NR);
  localparam logic [RW-1:0] ROUND_MID_END = RW'(NR - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] count_q, count_d;

  logic in_ready_q, sel_init_q, sel_final_q, state_we_q, busy_q, out_valid_q;

  // Handshakes: a block is accepted on the edge where start=1 and in_ready=1;
  // the result is taken on the edge where out_valid=1 and out_ready=1. abort
  // beats both, so an aborted result is never counted.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        round_d = '0;
        if (start && !abort) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        round_d = RW'(1);
        state_d = (NR == 1) ? S_FINAL : S_ROUND;
      end
      S_ROUND: begin
        if (round_q == ROUND_MID_END) begin
          state_d = S_FINAL;
          round_d = ROUND_LAST;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      S_FINAL: begin
        state_d = S_DONE;
        round_d = ROUND_LAST;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          round_d = '0;
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      round_d = '0;
      count_d = count_q;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      sel_init_q  <= 1'b0;
      sel_final_q <= 1'b0;
      state_we_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d == S_IDLE);
      sel_init_q  <= (state_d == S_INIT);
      sel_final_q <= (state_d == S_FINAL);
      state_we_q  <= (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign round       = round_q;
  assign sel_init    = sel_init_q;
  assign sel_final   = sel_final_q;
  assign state_we    = state_we_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign block_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: NR=10/CW=16 main instance plus an NR=1/CW=2
// instance for the short sequence and counter wrap.
module tb_aes_enc_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;
  localparam int CW = 16;
  localparam int W  = RW + 6 + CW;

  // flag fields: sel_init, sel_final, state_we, busy, out_valid, in_ready
  localparam int F_INIT  = 6'b101100;
  localparam int F_ROUND = 6'b001100;
  localparam int F_FINAL = 6'b011100;
  localparam int F_DONE  = 6'b000110;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start, abort, out_ready;
  logic          in_ready, sel_init, sel_final, state_we, busy, out_valid;
  logic [RW-1:0] round;
  logic [CW-1:0] block_count;
  logic [2:0]    dbg_state;

  logic          start1, abort1, out_ready1;
  logic          in_ready1, sel_init1, sel_final1, state_we1, busy1, out_valid1;
  logic [RW-1:0] round1;
  logic [1:0]    block_count1;
  logic [2:0]    dbg_state1;

  aes_enc_round_ctrl #(.NR(NR), .RW(RW), .CW(CW)) u_dut (
    .clock(clk), .reset(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .in_ready(in_ready), .round(round), .sel_init(sel_init), .sel_final(sel_final),
    .state_we(state_we), .busy(busy), .out_valid(out_valid),
    .block_count(block_count), .dbg_state(dbg_state)
  );

  aes_enc_round_ctrl #(.NR(1), .RW(RW), .CW(2)) u_dut1 (
    .clock(clk), .reset(rst_n), .start(start1), .abort(abort1), .out_ready(out_ready1),
    .in_ready(in_ready1), .round(round1), .sel_init(sel_init1), .sel_final(sel_final1),
    .state_we(state_we1), .busy(busy1), .out_valid(out_valid1),
    .block_count(block_count1), .dbg_state(dbg_state1)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  int exp_bc  = 0;
  int exp_bc1 = 0;

  function automatic logic [W-1:0] mk(input int r, input int flags, input int bc);
    return {r[RW-1:0], flags[5:0], bc[CW-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitors: every busy cycle pops one expected output vector; idle cycles
  // must show the idle output values
  always @(negedge clk) begin : mon0
    logic [W-1:0] act;
    act = {round, sel_init, sel_final, state_we, busy, out_valid, in_ready, block_count};
    if (busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_busy: got %0h expected no busy cycle at %0t", act, $time);
      end else begin
        check("trace", 32'(act), 32'(exp_q.pop_front()));
      end
    end else begin
      check("idle_outputs", 32'({round, sel_init, sel_final, state_we, out_valid, in_ready}),
            32'({4'd0, 5'b00000, 1'b1}));
    end
  end

  always @(negedge clk) begin : mon1
    logic [W-1:0] act;
    act = {round1, sel_init1, sel_final1, state_we1, busy1, out_valid1, in_ready1, 14'd0, block_count1};
    if (busy1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_busy_nr1: got %0h expected no busy cycle at %0t", act, $time);
      end else begin
        check("trace_nr1", 32'(act), 32'(exp1_q.pop_front()));
      end
    end else begin
      check("idle_outputs_nr1", 32'({round1, sel_init1, sel_final1, state_we1, out_valid1, in_ready1}),
            32'({4'd0, 5'b00000, 1'b1}));
    end
  end

  // driver tasks (called at posedge+1 with the DUT idle)
  task automatic run_block(input int hold, input bit abort_done);
    int bc = exp_bc;
    exp_q.push_back(mk(0, F_INIT, bc));
    for (int r = 1; r < NR; r++) exp_q.push_back(mk(r, F_ROUND, bc));
    exp_q.push_back(mk(NR, F_FINAL, bc));
    for (int i = 0; i <= hold; i++) exp_q.push_back(mk(NR, F_DONE, bc));
    start = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (NR + 1) @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      start = ~start;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    abort = abort_done;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b0;
    if (!abort_done) exp_bc = (exp_bc + 1) % 65536;
    check("after_in_ready", 32'(in_ready), 32'd1);
    check("after_round", 32'(round), 32'd0);
    check("after_out_valid", 32'(out_valid), 32'd0);
    check("block_count", 32'(block_count), 32'(exp_bc));
  endtask

  task automatic run_block1();
    exp1_q.push_back(mk(0, F_INIT, exp_bc1));
    exp1_q.push_back(mk(1, F_FINAL, exp_bc1));
    exp1_q.push_back(mk(1, F_DONE, exp_bc1));
    start1 = 1'b1;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    exp_bc1 = (exp_bc1 + 1) % 4;
    check("nr1_in_ready", 32'(in_ready1), 32'd1);
    check("nr1_block_count", 32'(block_count1), 32'(exp_bc1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_round", 32'(round), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state_we", 32'(state_we), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_block_count", 32'(block_count), 32'd0);
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single block, then a held result with start pulses ignored
    run_block(0, 1'b0);
    run_block(5, 1'b0);

    // abort at round 5
    start = 1'b1;
    exp_q.push_back(mk(0, F_INIT, exp_bc));
    for (int r = 1; r <= 5; r++) exp_q.push_back(mk(r, F_ROUND, exp_bc));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_at_round", 32'(round), 32'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_round", 32'(round), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_block_count", 32'(block_count), 32'(exp_bc));
    @(posedge clk); #1;
    run_block(0, 1'b0);

    // abort beats out_ready in DONE
    run_block(0, 1'b1);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("idle_abort_busy", 32'(busy), 32'd0);

    // asynchronous reset in round 7
    start = 1'b1;
    exp_q.push_back(mk(0, F_INIT, exp_bc));
    for (int r = 1; r <= 7; r++) exp_q.push_back(mk(r, F_ROUND, exp_bc));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_round", 32'(round), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_state_we", 32'(state_we), 32'd0);
    check("arst_block_count", 32'(block_count), 32'd0);
    exp_bc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(0, 1'b0);

    // NR=1 sequence and 2-bit counter wrap 3 -> 0
    for (int i = 0; i < 5; i++) run_block1();

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
